// File: rtl/mod_inv.sv
// mod_inv: sequential modular inverse c = a^(q-2) mod q (Fermat's little theorem).
//   select_i = 1 : Kyber,     q = 3329
//   select_i = 0 : Dilithium, q = 8380417
// One mod_mul is shared by every step. The exponent is walked MSB first with
// square-and-multiply, one modular multiplication per clock.
//
// Optional feature macro: MOD_INV_ZERO_FLAG_EN
//   When defined, an err_o port is added and a zero operand completes one
//   cycle after acceptance with done_o and err_o pulsing together.
//   When undefined, a zero operand runs the full latency and returns 0.
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for start_i, ready_o high
//   RUN     | one square or multiply step per cycle
//   ZERO    | zero operand short-cut (only reachable with MOD_INV_ZERO_FLAG_EN)

// Combinational modular multiplier using Barrett reduction for both moduli.
// For q with 2^(k-1) < q < 2^k and mu = floor(4^k / q), the quotient estimate
// ((p >> (k-1)) * mu) >> (k+1) undershoots by at most 2, so the remainder is
// below 3q and two conditional subtractions finish the reduction. Remainders
// are formed modulo 2^(k+2), which is exact because the true value is < 3q.
module mod_mul (
    input  logic        sel_i,
    input  logic [22:0] a_i,
    input  logic [22:0] b_i,
    output logic [22:0] p_o
);

    localparam logic [13:0] Q_KYBER  = 14'd3329;
    localparam logic [25:0] MU_KYBER = 26'd5039;
    localparam logic [24:0] Q_DIL    = 25'd8380417;
    localparam logic [47:0] MU_DIL   = 48'd8396807;

    logic [23:0] prod_k;
    logic [12:0] qh_k;
    logic [13:0] r0_k;
    logic [13:0] r1_k;
    logic [13:0] r2_k;

    logic [45:0] prod_d;
    logic [23:0] qh_d;
    logic [24:0] r0_d;
    logic [24:0] r1_d;
    logic [24:0] r2_d;

    // Kyber path: 12-bit operands, k = 12
    always_comb begin
        prod_k = {12'b0, a_i[11:0]} * {12'b0, b_i[11:0]};
        qh_k   = 13'(({13'b0, prod_k[23:11]} * MU_KYBER) >> 13);
        r0_k   = prod_k[13:0] - 14'({1'b0, qh_k} * Q_KYBER);
        r1_k   = (r0_k >= Q_KYBER) ? (r0_k - Q_KYBER) : r0_k;
        r2_k   = (r1_k >= Q_KYBER) ? (r1_k - Q_KYBER) : r1_k;
    end

    // Dilithium path: 23-bit operands, k = 23
    always_comb begin
        prod_d = {23'b0, a_i} * {23'b0, b_i};
        qh_d   = 24'(({24'b0, prod_d[45:22]} * MU_DIL) >> 24);
        r0_d   = prod_d[24:0] - 25'({1'b0, qh_d} * Q_DIL);
        r1_d   = (r0_d >= Q_DIL) ? (r0_d - Q_DIL) : r0_d;
        r2_d   = (r1_d >= Q_DIL) ? (r1_d - Q_DIL) : r1_d;
    end

    // Result select, Kyber results are zero-extended
    always_comb begin
        p_o = sel_i ? {11'b0, 12'(r2_k)} : 23'(r2_d);
    end

endmodule

module mod_inv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        select_i,
    input  logic [22:0] a_i,
    output logic        ready_o,
    output logic        done_o,
`ifdef MOD_INV_ZERO_FLAG_EN
    output logic        err_o,
`endif
    output logic [22:0] c_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ZERO = 2'd2;

    // q - 2 for each field; the MSB is consumed by loading acc with a
    localparam logic [22:0] EXP_KYBER       = 23'd3327;
    localparam logic [22:0] EXP_DIL         = 23'd8380415;
    localparam logic [4:0]  IDX_KYBER_START = 5'd10;
    localparam logic [4:0]  IDX_DIL_START   = 5'd21;

    logic [1:0]  state_q, state_d;
    logic        sel_q, sel_d;
    logic [22:0] a_q, a_d;
    logic [22:0] acc_q, acc_d;
    logic [4:0]  idx_q, idx_d;
    logic        mul_q, mul_d;
    logic [22:0] c_q, c_d;
    logic        done_q, done_d;
`ifdef MOD_INV_ZERO_FLAG_EN
    logic        err_q, err_d;
`endif

    logic [22:0] a_in;
    logic        exp_bit;
    logic [22:0] mm_b;
    logic [22:0] mm_p;

    mod_mul u_mod_mul (
        .sel_i (sel_q),
        .a_i   (acc_q),
        .b_i   (mm_b),
        .p_o   (mm_p)
    );

    // Operand as it will be captured, exponent bit under the index, multiplier input
    always_comb begin
        a_in    = select_i ? {11'b0, a_i[11:0]} : a_i;
        exp_bit = sel_q ? EXP_KYBER[idx_q] : EXP_DIL[idx_q];
        mm_b    = mul_q ? a_q : acc_q;
    end

    // Next-state logic: acceptance, square/multiply sequencing, completion
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        mul_d   = mul_q;
        c_d     = c_q;
        done_d  = 1'b0;
`ifdef MOD_INV_ZERO_FLAG_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sel_d   = select_i;
                    a_d     = a_in;
                    acc_d   = a_in;
                    idx_d   = select_i ? IDX_KYBER_START : IDX_DIL_START;
                    mul_d   = 1'b0;
                    state_d = ST_RUN;
`ifdef MOD_INV_ZERO_FLAG_EN
                    if (a_in == 23'd0) begin
                        state_d = ST_ZERO;
                    end
`endif
                end
            end
            ST_RUN: begin
                acc_d = mm_p;
                if (!mul_q && exp_bit) begin
                    mul_d = 1'b1;
                end else begin
                    mul_d = 1'b0;
                    if (idx_q == 5'd0) begin
                        state_d = ST_IDLE;
                        c_d     = mm_p;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - 5'd1;
                    end
                end
            end
            ST_ZERO: begin
                state_d = ST_IDLE;
                c_d     = 23'd0;
                done_d  = 1'b1;
`ifdef MOD_INV_ZERO_FLAG_EN
                err_d   = 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-run aborts silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            a_q     <= 23'd0;
            acc_q   <= 23'd0;
            idx_q   <= 5'd0;
            mul_q   <= 1'b0;
            c_q     <= 23'd0;
            done_q  <= 1'b0;
`ifdef MOD_INV_ZERO_FLAG_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            mul_q   <= mul_d;
            c_q     <= c_d;
            done_q  <= done_d;
`ifdef MOD_INV_ZERO_FLAG_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        ready_o = (state_q == ST_IDLE);
        done_o  = done_q;
        c_o     = c_q;
`ifdef MOD_INV_ZERO_FLAG_EN
        err_o   = err_q;
`endif
    end

endmodule

// File: tb/tb_mod_inv.sv
// Testbench for mod_inv: directed and random operands compared against a
// behavioural modular exponentiation model, plus latency, hold-off, reset
// abort, back-to-back and zero-operand scenarios.
module tb_mod_inv;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        select_i;
    logic [22:0] a_i;
    logic        ready_o;
    logic        done_o;
    logic [22:0] c_o;
`ifdef MOD_INV_ZERO_FLAG_EN
    logic        err_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    mod_inv dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .select_i (select_i),
        .a_i      (a_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
`ifdef MOD_INV_ZERO_FLAG_EN
        .err_o    (err_o),
`endif
        .c_o      (c_o)
    );

    // Reference: a^(q-2) mod q by LSB-first binary exponentiation
    function automatic longint ref_inv(input bit kyber, input longint a);
        longint q, r, b, e;
        q = kyber ? 64'd3329 : 64'd8380417;
        r = 1;
        b = a % q;
        e = q - 2;
        while (e > 0) begin
            if (e[0]) r = (r * b) % q;
            b = (b * b) % q;
            e = e >> 1;
        end
        return r;
    endfunction

    // One operation: start on a negedge, then count edges until done_o
    task automatic run_op(input bit sel, input logic [22:0] a,
                          output logic [22:0] c, output int lat, output bit err);
        @(negedge clk_i);
        start_i  = 1'b1;
        select_i = sel;
        a_i      = a;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        lat = -1;
        c   = 23'd0;
        err = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                lat = i;
                c   = c_o;
`ifdef MOD_INV_ZERO_FLAG_EN
                err = err_o;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        select_i = 1'b0;
        a_i = 23'd0;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %0b expected 1", ready_o);
        end
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %0b expected 0", done_o);
        end
        vectors++;
        if (c_o !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_c: got %0d expected 0", c_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_kyber();
        logic [22:0] c;
        int lat;
        bit err;
        int dir_a[3]   = '{2, 17, 1};
        int dir_exp[3] = '{1665, 1175, 1};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 23'(dir_a[i]), c, lat, err);
            vectors++;
            if (c !== 23'(dir_exp[i])) begin
                miscompares++;
                $display("FAIL kyber_dir a=%0d: got %0d expected %0d", dir_a[i], c, dir_exp[i]);
            end
            vectors++;
            if (lat != 20) begin
                miscompares++;
                $display("FAIL kyber_latency a=%0d: got %0d expected 20", dir_a[i], lat);
            end
        end
        for (int i = 0; i < 8; i++) begin
            int a;
            longint e;
            a = int'($urandom_range(1, 3328));
            e = ref_inv(1'b1, longint'(a));
            // upper bits of a_i must be ignored in Kyber mode
            run_op(1'b1, {11'($urandom), 12'(a)}, c, lat, err);
            vectors++;
            if (longint'(c) != e || lat != 20) begin
                miscompares++;
                $display("FAIL kyber_rand a=%0d: got %0d lat %0d expected %0d lat 20", a, c, lat, e);
            end
`ifdef MOD_INV_ZERO_FLAG_EN
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL kyber_err_nonzero a=%0d: got %0b expected 0", a, err);
            end
`endif
        end
    endtask

    task automatic test_dilithium();
        logic [22:0] c;
        int lat;
        bit err;
        run_op(1'b0, 23'd2, c, lat, err);
        vectors++;
        if (c !== 23'd4190209 || lat != 43) begin
            miscompares++;
            $display("FAIL dil_two: got %0d lat %0d expected 4190209 lat 43", c, lat);
        end
        run_op(1'b0, 23'd8380416, c, lat, err);
        vectors++;
        if (c !== 23'd8380416 || lat != 43) begin
            miscompares++;
            $display("FAIL dil_qm1: got %0d lat %0d expected 8380416 lat 43", c, lat);
        end
        for (int i = 0; i < 5; i++) begin
            int a;
            longint e;
            a = int'($urandom_range(1, 8380416));
            e = ref_inv(1'b0, longint'(a));
            run_op(1'b0, 23'(a), c, lat, err);
            vectors++;
            if (longint'(c) != e || lat != 43) begin
                miscompares++;
                $display("FAIL dil_rand a=%0d: got %0d lat %0d expected %0d lat 43", a, c, lat, e);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int a, pulses, lat, ready_bad;
        longint e;
        logic [22:0] c;
        a = int'($urandom_range(1, 8380416));
        e = ref_inv(1'b0, longint'(a));
        @(negedge clk_i);
        start_i  = 1'b1;
        select_i = 1'b0;
        a_i      = 23'(a);
        @(posedge clk_i);
        #1;
        pulses = 0;
        lat = -1;
        ready_bad = 0;
        c = 23'd0;
        for (int i = 1; i <= 90; i++) begin
            select_i = 1'($urandom);
            a_i      = 23'($urandom);
            @(posedge clk_i);
            #1;
            if (done_o) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    c = c_o;
                    start_i = 1'b0;
                end
            end else if (pulses == 0 && ready_o !== 1'b0) begin
                ready_bad++;
            end
        end
        start_i = 1'b0;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL hold_pulses: got %0d expected 1", pulses);
        end
        vectors++;
        if (longint'(c) != e || lat != 43) begin
            miscompares++;
            $display("FAIL hold_result a=%0d: got %0d lat %0d expected %0d lat 43", a, c, lat, e);
        end
        vectors++;
        if (ready_bad != 0) begin
            miscompares++;
            $display("FAIL hold_ready: got %0d cycles with ready high expected 0", ready_bad);
        end
    endtask

    task automatic test_reset_mid_run();
        int late_done;
        @(negedge clk_i);
        start_i  = 1'b1;
        select_i = 1'b0;
        a_i      = 23'd12345;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        vectors++;
        if (ready_o !== 1'b1 || c_o !== 23'd0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got ready %0b c %0d done %0b expected ready 1 c 0 done 0",
                     ready_o, c_o, done_o);
        end
        rst_i = 1'b0;
        late_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) late_done++;
        end
        vectors++;
        if (late_done != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", late_done);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [22:0] c1, c2;
        t1 = -1;
        t2 = -1;
        c1 = 23'd0;
        c2 = 23'd0;
        @(negedge clk_i);
        start_i  = 1'b1;
        select_i = 1'b1;
        a_i      = 23'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            if (done_o) begin
                if (t1 < 0) begin
                    t1 = i;
                    c1 = c_o;
                    start_i = 1'b1;
                    a_i = 23'd3328;
                end else if (t2 < 0) begin
                    t2 = i;
                    c2 = c_o;
                end
            end
        end
        vectors++;
        if (c1 !== 23'd1110 || t1 != 20) begin
            miscompares++;
            $display("FAIL b2b_first: got %0d at %0d expected 1110 at 20", c1, t1);
        end
        vectors++;
        if (c2 !== 23'd3328 || t2 - t1 != 21) begin
            miscompares++;
            $display("FAIL b2b_second: got %0d spacing %0d expected 3328 spacing 21", c2, t2 - t1);
        end
    endtask

    task automatic test_zero();
        logic [22:0] c;
        int lat;
        bit err;
        run_op(1'b1, 23'd0, c, lat, err);
`ifdef MOD_INV_ZERO_FLAG_EN
        vectors++;
        if (c !== 23'd0 || lat != 1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_flag: got c %0d lat %0d err %0b expected c 0 lat 1 err 1", c, lat, err);
        end
`else
        vectors++;
        if (c !== 23'd0 || lat != 20) begin
            miscompares++;
            $display("FAIL zero_full: got c %0d lat %0d expected c 0 lat 20", c, lat);
        end
`endif
        run_op(1'b0, 23'd0, c, lat, err);
`ifdef MOD_INV_ZERO_FLAG_EN
        vectors++;
        if (c !== 23'd0 || lat != 1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_flag_dil: got c %0d lat %0d err %0b expected c 0 lat 1 err 1", c, lat, err);
        end
`else
        vectors++;
        if (c !== 23'd0 || lat != 43) begin
            miscompares++;
            $display("FAIL zero_full_dil: got c %0d lat %0d expected c 0 lat 43", c, lat);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_kyber();
        test_dilithium();
        test_ignore_inputs();
        test_reset_mid_run();
        test_back_to_back();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
